riscv_core_dpath_vec_ldu: RTL and testbench
===========================================

RISCV_CORE_DPATH_VEC_LDU -- requirements
Module: riscv_core_dpath_vec_ldu

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of in-flight memory reads (1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port req_val, input, 1 bit: a load command is valid.
REQ-005 SHALL have port req_rdy, output, 1 bit: the unit accepts a command.
REQ-006 SHALL have port req_base, input, 32 bits: byte address of element 0.
REQ-007 SHALL have port req_stride, input, 32 bits: byte stride between elements.
REQ-008 SHALL have port req_vl, input, 4 bits: last element index; elements 0..vl are loaded.
REQ-009 SHALL have ports memreq_val (output, 1), memreq_rdy (input, 1) and memreq_addr (output, 32): the word-read request channel.
REQ-010 SHALL have ports memresp_val (input, 1) and memresp_data (input, 32): the in-order read response channel, with no backpressure.
REQ-011 SHALL have ports resp_val (output, 1), resp_rdy (input, 1), resp_vec (output, 256) and resp_vl (output, 4): the assembled vector that feeds the vector ALU vin operands.

Function
REQ-012 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-013 SHALL assert req_rdy only in IDLE; a command SHALL be accepted on req_val && req_rdy, after which the state moves to ISSUE.
REQ-014 SHALL clamp req_vl values 8..15 to 7 at accept; resp_vl SHALL carry the clamped value.
REQ-015 SHALL compute the address of element i as req_base + i*stride, modulo 2^32, wrapping silently.
REQ-016 SHALL, in ISSUE, assert memreq_val when outstanding < MAX_OUTST; each memreq_val && memreq_rdy cycle issues one element in ascending index order.
REQ-017 SHALL move from ISSUE to DRAIN after element vl is issued, and from DRAIN to DONE in the cycle after the last response arrives.
REQ-018 SHALL write each response into lane k bits [32k+31:32k] in arrival order, where k is the next unfilled index.
REQ-019 SHALL leave the outstanding count unchanged when an issue and a response occur in the same cycle.
REQ-020 SHALL ignore memresp_val when outstanding == 0 and SHALL flag it via a simulation-only assertion.
REQ-021 SHALL drive lanes with index greater than vl as zero in resp_vec.
REQ-022 SHALL assert resp_val in DONE and hold resp_vec and resp_vl stable until resp_rdy; on the handshake the state returns to IDLE, and req_rdy rises the following cycle.
REQ-023 SHALL, with memreq_rdy = 1 and 1-cycle memory, produce resp_val exactly vl+3 cycles after the accept edge.

Reset
REQ-024 SHALL, while reset_n = 0 (including mid-operation), force the state to IDLE, counters to 0, resp_vec to 0, resp_vl to 0, and req_rdy=1, memreq_val=0, resp_val=0 immediately.
REQ-025 SHALL discard in-flight responses arriving after reset release; outstanding SHALL restart at 0.

Configuration
REQ-026 SHALL, with RISCV_VEC_LDU_STRIDE_EN defined, use the latched req_stride.
REQ-027 SHALL, with RISCV_VEC_LDU_STRIDE_EN undefined, fix the stride at 4 bytes (unit stride) and ignore req_stride.

Structure
REQ-028 SHALL place the state enum, the element count 8, the element width 32 and the vl width 4 in the shared package riscv_vec_pkg.
REQ-029 SHALL place the response-lane write and zero masking in the single sub-module riscv_core_dpath_vec_ldu_asm.

Verification
REQ-030 SHALL cover unit stride: base=0x100, vl=3, memory word at addr=addr -> requests 0x100, 0x104, 0x108, 0x10C; resp_vec lanes 0..3 = 0x100..0x10C, lanes 4..7 = 0.
REQ-031 SHALL cover strided loads (STRIDE_EN): base=0x1000, stride=0x40, vl=7 -> last address 0x11C0; resp_val 10 cycles after accept.
REQ-032 SHALL cover backpressure: memreq_rdy toggling and 4-cycle memory latency with MAX_OUTST=2 -> never more than 2 outstanding; data correct.
REQ-033 SHALL cover wrap and clamp: base=0xFFFFFFFC, vl=15 -> resp_vl=7, addresses 0xFFFFFFFC, 0x0, ..., 0x18.
REQ-034 SHALL cover stalls and reset: resp_rdy=0 for 5 cycles -> resp_vec stable and req_rdy=0; reset_n pulse mid-ISSUE -> all outputs reset asynchronously and a new command completes correctly.

Source files
------------

// File: rtl/riscv_vec_pkg.sv
// Shared definitions for the vector load unit: element geometry, vl width,
// the load-unit state encoding and the vl clamp helper.
package riscv_vec_pkg;

   localparam int unsigned NUM_ELEM = 8;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned VL_W     = 4;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned VEC_W    = NUM_ELEM * DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ldu_state_e;

   // Requested vl beyond the last lane saturates to the last lane index.
   function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
      clamp_vl = (vl > VL_W'(NUM_ELEM - 1)) ? VL_W'(NUM_ELEM - 1) : vl;
   endfunction

endpackage

// File: rtl/riscv_core_dpath_vec_ldu_asm.sv
// Response assembly for the vector load unit: one 32-bit lane register per
// element, written in arrival order, with lanes above vl forced to zero.
module riscv_core_dpath_vec_ldu_asm
   import riscv_vec_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [VL_W-1:0]   vl,
   output logic [VEC_W-1:0]  vec
);

   logic [DATA_W-1:0] lane_q [NUM_ELEM];

   // Capture each accepted memory response into its lane.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ELEM; i++) begin
            lane_q[i] <= '0;
         end
      end else if (wr_en) begin
         lane_q[wr_idx] <= wr_data;
      end
   end

   // Present lanes 0..vl and zero the rest.
   always_comb begin
      vec = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         if (VL_W'(i) <= vl) begin
            vec[i*DATA_W +: DATA_W] = lane_q[i];
         end
      end
   end

endmodule

// File: rtl/riscv_core_dpath_vec_ldu.sv
// Vector load unit: accepts a (base, stride, vl) command, issues one word read
// per element with at most MAX_OUTST reads in flight, assembles the in-order
// responses into a 256-bit vector and hands it to the vector ALU.
// Build option: RISCV_VEC_LDU_STRIDE_EN -- when defined the command stride is
// used; otherwise the stride is fixed at 4 bytes and req_stride is ignored.
module riscv_core_dpath_vec_ldu
   import riscv_vec_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_val,
   output logic              req_rdy,
   input  logic [31:0]       req_base,
   input  logic [31:0]       req_stride,
   input  logic [VL_W-1:0]   req_vl,
   output logic              memreq_val,
   input  logic              memreq_rdy,
   output logic [31:0]       memreq_addr,
   input  logic              memresp_val,
   input  logic [DATA_W-1:0] memresp_data,
   output logic              resp_val,
   input  logic              resp_rdy,
   output logic [VEC_W-1:0]  resp_vec,
   output logic [VL_W-1:0]   resp_vl
);

   localparam logic [3:0] MAX_OUTST_C = 4'(MAX_OUTST);

   ldu_state_e       state_q, state_d;
   logic [VL_W-1:0]  vl_q;
   logic [IDX_W-1:0] issue_idx_q;
   logic [IDX_W-1:0] fill_idx_q;
   logic [3:0]       outst_q;
   logic [31:0]      addr_q;
   logic [31:0]      stride_sel;

   logic req_fire, memreq_fire, memresp_fire, last_issue;

`ifdef RISCV_VEC_LDU_STRIDE_EN
   logic [31:0] stride_q;
   assign stride_sel = stride_q;
`else
   logic unused_req_stride;
   assign unused_req_stride = ^req_stride;
   assign stride_sel        = 32'd4;
`endif

   assign req_fire     = req_val && req_rdy;
   assign memreq_fire  = memreq_val && memreq_rdy;
   // A response with nothing in flight is stale (e.g. from before a reset).
   assign memresp_fire = memresp_val && (outst_q != 4'd0);
   assign last_issue   = memreq_fire && (issue_idx_q == vl_q[IDX_W-1:0]);
   assign memreq_addr  = addr_q;
   assign resp_vl      = vl_q;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: DRAIN waits one cycle past the last response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_fire)          state_d = ST_ISSUE;
         ST_ISSUE: if (last_issue)        state_d = ST_DRAIN;
         ST_DRAIN: if (outst_q == 4'd0)   state_d = ST_DONE;
         ST_DONE:  if (resp_rdy)          state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      req_rdy    = (state_q == ST_IDLE);
      memreq_val = (state_q == ST_ISSUE) && (outst_q < MAX_OUTST_C);
      resp_val   = (state_q == ST_DONE);
   end

   // Command latch, element indices and in-flight read count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vl_q        <= '0;
         issue_idx_q <= '0;
         fill_idx_q  <= '0;
         outst_q     <= '0;
      end else if (req_fire) begin
         vl_q        <= clamp_vl(req_vl);
         issue_idx_q <= '0;
         fill_idx_q  <= '0;
         outst_q     <= '0;
      end else begin
         if (memreq_fire)  issue_idx_q <= issue_idx_q + IDX_W'(1);
         if (memresp_fire) fill_idx_q  <= fill_idx_q + IDX_W'(1);
         case ({memreq_fire, memresp_fire})
            2'b10:   outst_q <= outst_q + 4'd1;
            2'b01:   outst_q <= outst_q - 4'd1;
            default: outst_q <= outst_q;
         endcase
      end
   end

   // Running element address; wraps modulo 2^32.
   always_ff @(posedge clk) begin
      if (req_fire)         addr_q <= req_base;
      else if (memreq_fire) addr_q <= addr_q + stride_sel;
   end

`ifdef RISCV_VEC_LDU_STRIDE_EN
   // Stride latched with the command.
   always_ff @(posedge clk) begin
      if (req_fire) stride_q <= req_stride;
   end
`endif

   riscv_core_dpath_vec_ldu_asm u_asm (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (memresp_fire),
      .wr_idx  (fill_idx_q),
      .wr_data (memresp_data),
      .vl      (vl_q),
      .vec     (resp_vec)
   );

`ifndef SYNTHESIS
   // Flag responses that arrive with no read in flight.
   always @(posedge clk) begin
      if (reset_n) begin
         assert (!(memresp_val && (outst_q == 4'd0)))
            else $error("vec_ldu: memresp_val with no outstanding read");
      end
   end
`endif

endmodule

// File: tb/tb_riscv_core_dpath_vec_ldu.sv
// Scoreboard bench for riscv_core_dpath_vec_ldu with a latency-configurable
// in-order word memory that returns the word address as data.
module tb_riscv_core_dpath_vec_ldu;
   import riscv_vec_pkg::*;

   localparam int MAX_OUTST = 2;
`ifdef RISCV_VEC_LDU_STRIDE_EN
   localparam bit STRIDE_EN = 1'b1;
`else
   localparam bit STRIDE_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req_val;
   logic         req_rdy;
   logic [31:0]  req_base;
   logic [31:0]  req_stride;
   logic [3:0]   req_vl;
   logic         memreq_val;
   logic         memreq_rdy;
   logic [31:0]  memreq_addr;
   logic         memresp_val;
   logic [31:0]  memresp_data;
   logic         resp_val;
   logic         resp_rdy;
   logic [255:0] resp_vec;
   logic [3:0]   resp_vl;

   riscv_core_dpath_vec_ldu #(.MAX_OUTST(MAX_OUTST)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_val      (req_val),
      .req_rdy      (req_rdy),
      .req_base     (req_base),
      .req_stride   (req_stride),
      .req_vl       (req_vl),
      .memreq_val   (memreq_val),
      .memreq_rdy   (memreq_rdy),
      .memreq_addr  (memreq_addr),
      .memresp_val  (memresp_val),
      .memresp_data (memresp_data),
      .resp_val     (resp_val),
      .resp_rdy     (resp_rdy),
      .resp_vec     (resp_vec),
      .resp_vl      (resp_vl)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [255:0] vec; logic [3:0] vl; int lat; } exp_t;
   typedef struct { logic [31:0] addr; int due; } mem_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   mem_t        mq[$];

   int cyc        = 0;
   int lat_cfg    = 1;
   bit rdy_toggle = 1'b0;
   int out_cnt    = 0;
   int peak       = 0;

   // Memory model: checks request addresses, returns data after lat_cfg cycles.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset_n) begin
            if (memresp_val) begin
               mem_t m;
               m = mq.pop_front();
               out_cnt--;
            end
            if (memreq_val && memreq_rdy) begin
               if (addr_q.size() == 0) chk("req_expected", 256'(addr_q.size() != 0), 256'(1));
               else                    chk("req_addr", 256'(memreq_addr), 256'(addr_q.pop_front()));
               mq.push_back('{memreq_addr, cyc + lat_cfg});
               out_cnt++;
               if (out_cnt > peak) peak = out_cnt;
            end
         end
         #1;
         if (!reset_n) begin
            mq.delete();
            out_cnt = 0;
         end
         memresp_val  = reset_n && (mq.size() > 0) && (mq[0].due == cyc + 1);
         memresp_data = (mq.size() > 0) ? mq[0].addr : 32'h0;
         memreq_rdy   = rdy_toggle ? cyc[0] : 1'b1;
      end
   end

   function automatic logic [255:0] build_vec(input logic [31:0] base, input logic [31:0] es,
                                              input logic [3:0] cvl);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         if (i <= int'(cvl)) v[i*32 +: 32] = base + 32'(i) * es;
      end
      return v;
   endfunction

   task automatic start_cmd(input logic [31:0] base, input logic [31:0] stride,
                            input logic [3:0] vl, input int lat, output int acc);
      logic [3:0]  cvl;
      logic [31:0] es;
      int n;
      cvl = (vl > 4'd7) ? 4'd7 : vl;
      es  = STRIDE_EN ? stride : 32'd4;
      for (int i = 0; i <= int'(cvl); i++) addr_q.push_back(base + 32'(i) * es);
      exp_q.push_back('{build_vec(base, es, cvl), cvl, lat});
      req_base   = base;
      req_stride = stride;
      req_vl     = vl;
      req_val    = 1'b1;
      n = 0;
      while (!req_rdy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_rdy_wait", 256'(req_rdy), 256'(1));
      @(posedge clk); #1;
      acc        = cyc;
      req_val    = 1'b0;
      req_base   = $urandom;
      req_stride = $urandom;
      req_vl     = 4'($urandom_range(0, 15));
   endtask

   task automatic finish_cmd(input int acc, input int stall);
      exp_t e;
      logic [255:0] snap;
      int n;
      resp_rdy = (stall == 0);
      n = 0;
      while (!resp_val && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("resp_val_seen", 256'(resp_val), 256'(1));
      if (!resp_val || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("resp_vec", resp_vec, e.vec);
      chk("resp_vl", 256'(resp_vl), 256'(e.vl));
      if (e.lat >= 0) chk("latency", 256'(cyc - acc), 256'(e.lat));
      if (stall > 0) begin
         snap = resp_vec;
         repeat (stall) begin
            @(posedge clk); #1;
         end
         chk("stall_vec", resp_vec, snap);
         chk("stall_resp_val", 256'(resp_val), 256'(1));
         chk("stall_req_rdy", 256'(req_rdy), 256'(0));
         resp_rdy = 1'b1;
      end
      @(posedge clk); #1;
      chk("post_req_rdy", 256'(req_rdy), 256'(1));
      chk("post_resp_val", 256'(resp_val), 256'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_rdy"}, 256'(req_rdy), 256'(1));
      chk({tag, "_memreq_val"}, 256'(memreq_val), 256'(0));
      chk({tag, "_resp_val"}, 256'(resp_val), 256'(0));
      chk({tag, "_resp_vec"}, resp_vec, 256'(0));
      chk({tag, "_resp_vl"}, 256'(resp_vl), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      reset_n      = 1'b0;
      req_val      = 1'b0;
      req_base     = '0;
      req_stride   = '0;
      req_vl       = '0;
      memresp_val  = 1'b0;
      memresp_data = '0;
      memreq_rdy   = 1'b1;
      resp_rdy     = 1'b1;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Unit stride; a non-unit req_stride must be ignored without the option.
      start_cmd(32'h100, STRIDE_EN ? 32'd4 : 32'h40, 4'd3, 6, acc);
      finish_cmd(acc, 0);

      // Strided, full length.
      start_cmd(32'h1000, 32'h40, 4'd7, 10, acc);
      finish_cmd(acc, 0);

      // Single element.
      start_cmd(32'h600, 32'd4, 4'd0, 3, acc);
      finish_cmd(acc, 0);

      // Backpressure with slow memory: in-flight reads limited to MAX_OUTST.
      lat_cfg    = 4;
      rdy_toggle = 1'b1;
      peak       = 0;
      start_cmd(32'h2000, 32'd8, 4'd5, -1, acc);
      finish_cmd(acc, 0);
      chk("peak_outstanding", 256'(peak), 256'(MAX_OUTST));
      lat_cfg    = 1;
      rdy_toggle = 1'b0;

      // Address wrap and vl clamp.
      start_cmd(32'hFFFF_FFFC, 32'd4, 4'd15, 10, acc);
      finish_cmd(acc, 0);

      // Response stall.
      start_cmd(32'h300, 32'd4, 4'd2, 5, acc);
      finish_cmd(acc, 5);

      // Reset in the middle of ISSUE with reads in flight.
      lat_cfg = 4;
      start_cmd(32'h4000, 32'd4, 4'd7, -1, acc);
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      reset_n     = 1'b0;
      memresp_val = 1'b0;
      mq.delete();
      out_cnt = 0;
      exp_q.delete();
      addr_q.delete();
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      lat_cfg = 1;
      @(posedge clk); #1;
      start_cmd(32'h500, 32'd4, 4'd4, 7, acc);
      finish_cmd(acc, 0);
      chk("addr_queue_empty", 256'(addr_q.size()), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
